// File: rtl/rvm_mem_arbiter_if.sv
// rtl/rvm_mem_arbiter_if.sv - fetch/data request, response and memory bus signals of rvm_mem_arbiter
interface rvm_mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rsp_valid;
    logic [31:0] i_rdata;
    logic        i_error;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_wen;
    logic [3:0]  d_ben;
    logic        d_gnt;
    logic        d_rsp_valid;
    logic [31:0] d_rdata;
    logic        d_error;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic        mem_c_en;
    logic        mem_w_en;
    logic [3:0]  mem_b_en;
    logic        mem_error;
    logic        mem_stall;

    modport master (
        output i_req, i_addr, d_req, d_addr, d_wdata, d_wen, d_ben,
        output mem_rdata, mem_error, mem_stall,
        input  i_gnt, i_rsp_valid, i_rdata, i_error,
        input  d_gnt, d_rsp_valid, d_rdata, d_error,
        input  mem_addr, mem_wdata, mem_c_en, mem_w_en, mem_b_en
    );

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_wdata, d_wen, d_ben,
        input  mem_rdata, mem_error, mem_stall,
        output i_gnt, i_rsp_valid, i_rdata, i_error,
        output d_gnt, d_rsp_valid, d_rdata, d_error,
        output mem_addr, mem_wdata, mem_c_en, mem_w_en, mem_b_en
    );
endinterface

// File: rtl/rvm_mem_arbiter.sv
// rtl/rvm_mem_arbiter.sv - shares one memory port between fetch (I) and load/store (D) requesters
// Optional macro RVM_ARB_ROUND_ROBIN_EN: alternate winners on contended grants instead of D-over-I priority.
module rvm_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic               clk,
    input  logic               reset,
    rvm_mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    state_t           r_state, w_next;
    logic [31:0]      r_addr, r_wdata, r_rdata;
    logic             r_wen, r_error, r_owner_d;
    logic [3:0]       r_ben;
    logic [CNT_W-1:0] r_cnt;
    logic             w_busy, w_i_gnt, w_d_gnt, w_done, w_abort, w_pref_d;

`ifdef RVM_ARB_ROUND_ROBIN_EN
    logic r_last_d;   // 1 = D won the previous contended arbitration
    assign w_pref_d = !r_last_d;
`else
    assign w_pref_d = 1'b1;
`endif

    assign w_busy = (r_state == BUSY_I) || (r_state == BUSY_D);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
        w_done  = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            IDLE: begin
                if (!reset) begin
                    if (bus.d_req && (!bus.i_req || w_pref_d)) begin
                        w_d_gnt = 1'b1;
                        w_next  = BUSY_D;
                    end else if (bus.i_req) begin
                        w_i_gnt = 1'b1;
                        w_next  = BUSY_I;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (!bus.mem_stall) begin
                    w_done = 1'b1;
                    w_next = RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TO_LAST))) begin
                    w_abort = 1'b1;
                    w_next  = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wen     <= 1'b0;
            r_ben     <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_error   <= 1'b0;
            r_owner_d <= 1'b0;
        end else begin
            if (w_d_gnt) begin
                r_addr    <= bus.d_addr;
                r_wdata   <= bus.d_wdata;
                r_wen     <= bus.d_wen;
                r_ben     <= bus.d_ben;
                r_owner_d <= 1'b1;
            end else if (w_i_gnt) begin
                r_addr    <= bus.i_addr;
                r_wen     <= 1'b0;
                r_ben     <= 4'b1111;
                r_owner_d <= 1'b0;
            end
            if (w_done || w_abort) r_cnt <= '0;
            else if (w_busy)       r_cnt <= r_cnt + 1'b1;
            if (w_done) begin
                r_rdata <= r_wen ? 32'h0 : bus.mem_rdata;
                r_error <= bus.mem_error;
            end else if (w_abort) begin
                r_rdata <= 32'h0;
                r_error <= 1'b1;
            end
        end
    end

`ifdef RVM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset)                        r_last_d <= 1'b0;
        else if (w_d_gnt && bus.i_req)    r_last_d <= 1'b1;
        else if (w_i_gnt && bus.d_req)    r_last_d <= 1'b0;
    end
`endif

    assign bus.i_gnt       = w_i_gnt;
    assign bus.d_gnt       = w_d_gnt;
    assign bus.mem_c_en    = w_busy;
    assign bus.mem_w_en    = w_busy && r_wen;
    assign bus.mem_b_en    = w_busy ? r_ben : 4'b0000;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_wdata   = r_wdata;
    assign bus.i_rsp_valid = (r_state == RESP) && !r_owner_d;
    assign bus.d_rsp_valid = (r_state == RESP) && r_owner_d;
    assign bus.i_rdata     = r_rdata;
    assign bus.d_rdata     = r_rdata;
    assign bus.i_error     = r_error;
    assign bus.d_error     = r_error;
endmodule

// File: tb/tb_rvm_mem_arbiter.sv
// tb/tb_rvm_mem_arbiter.sv - directed vector bench for rvm_mem_arbiter
module tb_rvm_mem_arbiter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    rvm_mem_arbiter_if bus ();

    rvm_mem_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        dwen;
        logic [3:0]  dben;
        logic [31:0] mrdata;
        logic        merr;
        logic        mstall;
        logic [1:0]  gnt;     // {d,i}
        logic [1:0]  rv;      // {d,i}
        logic [31:0] rdata;
        logic        err;
        logic        cen;
        logic        wen;
        logic [3:0]  ben;
        logic [31:0] maddr;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(
        input logic rst, input logic ireq, input logic [31:0] iaddr,
        input logic dreq, input logic [31:0] daddr, input logic [31:0] dwdata,
        input logic dwen, input logic [3:0] dben, input logic [31:0] mrdata,
        input logic merr, input logic mstall, input logic [1:0] gnt, input logic [1:0] rv,
        input logic [31:0] rdata, input logic err, input logic cen, input logic wen,
        input logic [3:0] ben, input logic [31:0] maddr, input logic [31:0] wdata);
        vec_t v;
        v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.daddr = daddr;
        v.dwdata = dwdata; v.dwen = dwen; v.dben = dben; v.mrdata = mrdata; v.merr = merr;
        v.mstall = mstall; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.err = err;
        v.cen = cen; v.wen = wen; v.ben = ben; v.maddr = maddr; v.wdata = wdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.d_wen = 0; bus.d_ben = 0; bus.mem_rdata = 0; bus.mem_error = 0; bus.mem_stall = 0;
    endtask

    logic exp_d_first;

    initial begin
        n_checks = 0;
        n_fail   = 0;
`ifdef RVM_ARB_ROUND_ROBIN_EN
        exp_d_first = 1'b0;
`else
        exp_d_first = 1'b1;
`endif
        //            rst ireq iaddr     dreq daddr     dwdata        dwen dben   mrdata      merr stl  gnt rv rdata       err cen wen ben    maddr     wdata
        vecs[0]  = mk(1, 1, 32'h100, 0, 32'h0,    32'h0,        0, 4'h0, 32'h0,      0, 0, 0, 0, 32'h0,      0, 0, 0, 4'h0, 32'h0,    32'h0);
        vecs[1]  = mk(0, 1, 32'h100, 0, 32'h0,    32'h0,        0, 4'h0, 32'h13,     0, 0, 1, 0, 32'h0,      0, 0, 0, 4'h0, 32'h0,    32'h0);
        vecs[2]  = mk(0, 0, 32'h0,   0, 32'h0,    32'h0,        0, 4'h0, 32'h13,     0, 0, 0, 0, 32'h0,      0, 1, 0, 4'hF, 32'h100,  32'h0);
        vecs[3]  = mk(0, 0, 32'h0,   0, 32'h0,    32'h0,        0, 4'h0, 32'h0,      0, 0, 0, 1, 32'h13,     0, 0, 0, 4'h0, 32'h100,  32'h0);
        vecs[4]  = mk(0, 0, 32'h0,   1, 32'h2004, 32'hDEADBEEF, 1, 4'h3, 32'h0,      0, 0, 2, 0, 32'h0,      0, 0, 0, 4'h0, 32'h100,  32'h0);
        vecs[5]  = mk(0, 0, 32'h0,   0, 32'h0,    32'h0,        0, 4'h0, 32'h0,      0, 1, 0, 0, 32'h0,      0, 1, 1, 4'h3, 32'h2004, 32'hDEADBEEF);
        vecs[6]  = mk(0, 0, 32'h0,   0, 32'h0,    32'h0,        0, 4'h0, 32'h0,      0, 1, 0, 0, 32'h0,      0, 1, 1, 4'h3, 32'h2004, 32'hDEADBEEF);
        vecs[7]  = mk(0, 0, 32'h0,   0, 32'h0,    32'h0,        0, 4'h0, 32'h0,      0, 1, 0, 0, 32'h0,      0, 1, 1, 4'h3, 32'h2004, 32'hDEADBEEF);
        vecs[8]  = mk(0, 0, 32'h0,   0, 32'h0,    32'h0,        0, 4'h0, 32'h55,     0, 0, 0, 0, 32'h0,      0, 1, 1, 4'h3, 32'h2004, 32'hDEADBEEF);
        vecs[9]  = mk(0, 0, 32'h0,   0, 32'h0,    32'h0,        0, 4'h0, 32'h0,      0, 0, 0, 2, 32'h0,      0, 0, 0, 4'h0, 32'h2004, 32'h0);
        vecs[10] = mk(0, 1, 32'h200, 0, 32'h0,    32'h0,        0, 4'h0, 32'hABCD,   1, 0, 1, 0, 32'h0,      0, 0, 0, 4'h0, 32'h2004, 32'h0);
        vecs[11] = mk(0, 0, 32'h0,   0, 32'h0,    32'h0,        0, 4'h0, 32'hABCD,   1, 0, 0, 0, 32'h0,      0, 1, 0, 4'hF, 32'h200,  32'h0);
        vecs[12] = mk(0, 0, 32'h0,   0, 32'h0,    32'h0,        0, 4'h0, 32'h0,      0, 0, 0, 1, 32'hABCD,   1, 0, 0, 4'h0, 32'h200,  32'h0);
        vecs[13] = mk(0, 1, 32'h300, 1, 32'h400,  32'h0,        0, 4'hF, 32'h11,     0, 0, 2, 0, 32'h0,      0, 0, 0, 4'h0, 32'h200,  32'h0);
        vecs[14] = mk(0, 1, 32'h300, 0, 32'h0,    32'h0,        0, 4'h0, 32'h11,     0, 0, 0, 0, 32'h0,      0, 1, 0, 4'hF, 32'h400,  32'h0);
        vecs[15] = mk(0, 1, 32'h300, 0, 32'h0,    32'h0,        0, 4'h0, 32'h0,      0, 0, 0, 2, 32'h11,     0, 0, 0, 4'h0, 32'h400,  32'h0);
        vecs[16] = mk(0, 1, 32'h300, 0, 32'h0,    32'h0,        0, 4'h0, 32'h22,     0, 0, 1, 0, 32'h0,      0, 0, 0, 4'h0, 32'h400,  32'h0);
        vecs[17] = mk(0, 0, 32'h0,   0, 32'h0,    32'h0,        0, 4'h0, 32'h22,     0, 0, 0, 0, 32'h0,      0, 1, 0, 4'hF, 32'h300,  32'h0);
        vecs[18] = mk(0, 0, 32'h0,   0, 32'h0,    32'h0,        0, 4'h0, 32'h0,      0, 0, 0, 1, 32'h22,     0, 0, 0, 4'h0, 32'h300,  32'h0);

        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            reset         = vecs[k].rst;
            bus.i_req     = vecs[k].ireq;   bus.i_addr    = vecs[k].iaddr;
            bus.d_req     = vecs[k].dreq;   bus.d_addr    = vecs[k].daddr;
            bus.d_wdata   = vecs[k].dwdata; bus.d_wen     = vecs[k].dwen;
            bus.d_ben     = vecs[k].dben;   bus.mem_rdata = vecs[k].mrdata;
            bus.mem_error = vecs[k].merr;   bus.mem_stall = vecs[k].mstall;
            #1;
            chk($sformatf("v%0d_i_gnt", k), bus.i_gnt, vecs[k].gnt[0]);
            chk($sformatf("v%0d_d_gnt", k), bus.d_gnt, vecs[k].gnt[1]);
            chk($sformatf("v%0d_i_rsp_valid", k), bus.i_rsp_valid, vecs[k].rv[0]);
            chk($sformatf("v%0d_d_rsp_valid", k), bus.d_rsp_valid, vecs[k].rv[1]);
            chk($sformatf("v%0d_mem_c_en", k), bus.mem_c_en, vecs[k].cen);
            chk($sformatf("v%0d_mem_w_en", k), bus.mem_w_en, vecs[k].wen);
            chk($sformatf("v%0d_mem_b_en", k), bus.mem_b_en, vecs[k].ben);
            chk($sformatf("v%0d_mem_addr", k), bus.mem_addr, vecs[k].maddr);
            if (vecs[k].wen) chk($sformatf("v%0d_mem_wdata", k), bus.mem_wdata, vecs[k].wdata);
            if (vecs[k].rv[0]) begin
                chk($sformatf("v%0d_i_rdata", k), bus.i_rdata, vecs[k].rdata);
                chk($sformatf("v%0d_i_error", k), bus.i_error, vecs[k].err);
            end
            if (vecs[k].rv[1]) begin
                chk($sformatf("v%0d_d_rdata", k), bus.d_rdata, vecs[k].rdata);
                chk($sformatf("v%0d_d_error", k), bus.d_error, vecs[k].err);
            end
        end

        // Second contended round: fixed priority gives D again, round robin gives I.
        @(negedge clk);
        clear_inputs();
        bus.i_req = 1; bus.i_addr = 32'h500;
        bus.d_req = 1; bus.d_addr = 32'h600; bus.d_ben = 4'hF; bus.mem_rdata = 32'h33;
        #1;
        chk("rr1_d_gnt", bus.d_gnt, exp_d_first);
        chk("rr1_i_gnt", bus.i_gnt, !exp_d_first);
        @(negedge clk);
        if (exp_d_first) bus.d_req = 0; else bus.i_req = 0;
        #1;
        chk("rr1_addr", bus.mem_addr, exp_d_first ? 32'h600 : 32'h500);
        chk("rr1_c_en", bus.mem_c_en, 1);
        @(negedge clk); #1;
        chk("rr1_d_rsp", bus.d_rsp_valid, exp_d_first);
        chk("rr1_i_rsp", bus.i_rsp_valid, !exp_d_first);
        chk("rr1_rdata", exp_d_first ? bus.d_rdata : bus.i_rdata, 32'h33);
        @(negedge clk); #1;
        chk("rr2_d_gnt", bus.d_gnt, !exp_d_first);
        chk("rr2_i_gnt", bus.i_gnt, exp_d_first);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("rr2_addr", bus.mem_addr, exp_d_first ? 32'h500 : 32'h600);
        @(negedge clk); #1;
        chk("rr2_d_rsp", bus.d_rsp_valid, !exp_d_first);
        chk("rr2_i_rsp", bus.i_rsp_valid, exp_d_first);

        // Timeout: load with stall held high, response exactly 17 cycles after grant.
        @(negedge clk);
        clear_inputs();
        bus.d_req = 1; bus.d_addr = 32'h700; bus.d_ben = 4'hF;
        bus.mem_stall = 1; bus.mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("to_d_gnt", bus.d_gnt, 1);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            bus.d_req = 0;
            #1;
            chk($sformatf("to_c%0d_d_rsp", c), bus.d_rsp_valid, (c == 17) ? 1 : 0);
            chk($sformatf("to_c%0d_c_en", c), bus.mem_c_en, (c == 17) ? 0 : 1);
            if (c == 17) begin
                chk("to_d_error", bus.d_error, 1);
                chk("to_d_rdata", bus.d_rdata, 32'h0);
            end
        end

        // Reset during a stalled store; the dropped transfer never responds.
        @(negedge clk);
        clear_inputs();
        bus.d_req = 1; bus.d_addr = 32'h800; bus.d_wdata = 32'h1234; bus.d_wen = 1; bus.d_ben = 4'hF;
        bus.mem_stall = 1;
        #1;
        chk("rst_d_gnt", bus.d_gnt, 1);
        @(negedge clk);
        bus.d_req = 0;
        #1;
        chk("rst_busy_c_en", bus.mem_c_en, 1);
        @(negedge clk);
        reset = 1; bus.i_req = 1; bus.i_addr = 32'h900;
        #1;
        chk("rst_high_i_gnt", bus.i_gnt, 0);
        @(negedge clk);
        reset = 0;
        #1;
        chk("rst_after_c_en", bus.mem_c_en, 0);
        chk("rst_after_addr", bus.mem_addr, 32'h0);
        chk("rst_after_i_gnt", bus.i_gnt, 1);
        chk("rst_after_d_rsp", bus.d_rsp_valid, 0);
        @(negedge clk);
        bus.i_req = 0; bus.mem_stall = 0; bus.mem_rdata = 32'h77;
        #1;
        chk("rst_fetch_addr", bus.mem_addr, 32'h900);
        chk("rst_fetch_w_en", bus.mem_w_en, 0);
        chk("rst_fetch_d_rsp", bus.d_rsp_valid, 0);
        @(negedge clk); #1;
        chk("rst_fetch_i_rsp", bus.i_rsp_valid, 1);
        chk("rst_fetch_rdata", bus.i_rdata, 32'h77);
        chk("rst_fetch_no_d_rsp", bus.d_rsp_valid, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk($sformatf("rst_quiet%0d_d_rsp", c), bus.d_rsp_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rvm_mem_arbiter.md
Name: rvm_mem_arbiter

Overview:
Shares the core's single memory port between two requesters: the instruction fetch path (port I) and the load/store path (port D). It accepts one request at a time, drives the memory bus until the transfer completes or times out, and returns read data and an error flag to the owning requester. It sits between the control unit's memory-side outputs and the top-level mem_* pins.

Parameters:
TIMEOUT_CYCLES, 16, stall cycles tolerated before a transfer is aborted with an error; 0 disables the timeout.
CNT_W, 5, width of the stall counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
i_req  in  1  fetch request; held until i_gnt.
i_addr  in  32  fetch address.
i_gnt  out  1  combinational; fetch request accepted this cycle.
i_rsp_valid  out  1  one-cycle pulse; fetch transfer finished.
i_rdata  out  32  fetch read data; valid with i_rsp_valid.
i_error  out  1  fetch bus error or timeout; valid with i_rsp_valid.
d_req  in  1  load/store request; held until d_gnt.
d_addr  in  32  data address.
d_wdata  in  32  store data.
d_wen  in  1  1 = store, 0 = load.
d_ben  in  4  byte enables.
d_gnt  out  1  combinational; data request accepted this cycle.
d_rsp_valid  out  1  one-cycle pulse; data transfer finished.
d_rdata  out  32  load data; valid with d_rsp_valid.
d_error  out  1  bus error or timeout; valid with d_rsp_valid.
mem_addr  out  32  memory address.
mem_rdata  in  32  memory read data.
mem_wdata  out  32  memory write data.
mem_c_en  out  1  memory chip enable.
mem_w_en  out  1  memory write enable.
mem_b_en  out  4  memory byte enable.
mem_error  in  1  memory error indicator.
mem_stall  in  1  memory stall indicator.

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - Grant selection: d_req wins over i_req (fixed priority). Assert the matching gnt in the same cycle.
  - Latch addr, wdata, wen and ben into the transfer registers. A fetch latches wen=0 and ben=4'b1111.
  - Next state is BUSY_I or BUSY_D. No request: stay in IDLE.
- Bus drive while BUSY_x:
  - mem_c_en=1; mem_addr, mem_wdata, mem_w_en and mem_b_en come from the transfer registers.
  - All bus outputs are stable for the whole transfer.
- Outside BUSY_x: mem_c_en=0, mem_w_en=0, mem_b_en=0; addr and wdata hold their last value.
- Completion in BUSY_x, when mem_stall=0:
  - Capture mem_rdata and mem_error into the response registers.
  - Clear the stall counter and go to RESP.
  - Store transfers capture rdata as 0.
- Stall in BUSY_x, when mem_stall=1:
  - Increment the stall counter.
  - If TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1, abort: capture rdata=0 and error=1, then go to RESP.
- RESP (one cycle): pulse x_rsp_valid for the owner only, with x_rdata and x_error from the response registers. Next state is IDLE.
- gnt is never asserted outside IDLE.
- Latency with no stall: req/gnt in cycle 0, mem_c_en in cycle 1, rsp_valid in cycle 2, next grant possible in cycle 3. Each stall cycle adds one cycle.
- x_rdata and x_error hold their value between pulses; they are meaningful only with rsp_valid.
- Reset, including mid-transfer:
  - State becomes IDLE, and the stall counter and response registers clear to 0.
  - All outputs read 0 from the next cycle; the in-flight transfer is dropped with no rsp_valid.
- While reset is high: gnt=0.
- i_req and d_req must not change address or data before gnt; behaviour when they do is undefined.

Optional Feature:
RVM_ARB_ROUND_ROBIN_EN
- Defined: when both requests are pending in IDLE, grant the port that did NOT win the previous contended arbitration. Uncontended grants do not update the last-winner flag. The flag resets to "I won last", so the first contended grant goes to D.
- Undefined: fixed priority, D over I.

Test Plan:
1. Single fetch: i_req=1, i_addr=0x100, mem_stall=0, mem_rdata=0x00000013 -> i_gnt in cycle 0; cycle 1 mem_c_en=1, mem_addr=0x100, mem_w_en=0, mem_b_en=4'hF; cycle 2 i_rsp_valid=1, i_rdata=0x13, i_error=0.
2. Store with 3 stalls: d_req, d_wen=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_ben=4'b0011, mem_stall high for 3 cycles -> bus outputs constant for 4 cycles; d_rsp_valid 5 cycles after grant, d_error=0; i_rsp_valid never pulses.
3. Contention: i_req and d_req both high from cycle 0 -> d_gnt in cycle 0, i_gnt in cycle 3. With RVM_ARB_ROUND_ROBIN_EN, a second contended round grants I first.
4. Timeout: TIMEOUT_CYCLES=16, load with mem_stall held high -> d_rsp_valid with d_error=1 and d_rdata=0 exactly 17 cycles after grant; mem_c_en drops in the RESP cycle.
5. Bus error: fetch with mem_error=1 and mem_stall=0 in the completion cycle -> i_error=1 on i_rsp_valid.
6. Reset mid-transfer: reset=1 for 1 cycle during a stalled BUSY_D -> next cycle mem_c_en=0, no d_rsp_valid ever, a new i_req is granted on the first cycle after reset deasserts.
